lsu_writeback: RTL and testbench

//  Memory/write-back stage downstream of execute. Consumes the ALU result (address or data)
//  and the rs2 store data, runs a handshaked data-memory transaction for LB/LH/LW/LBU/LHU/SB/SH/SW,
//  and returns rd write data, address and enable to the register file. Handles byte-lane

---
 rtl/lsu_writeback.sv | 217 +++++++++++++++++++++
 tb/tb_lsu_writeback.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_writeback.sv
// Memory / write-back stage: drives one data-memory transaction per load or store and
// returns the steered, extended result to the register file. ALU results pass straight through.
// Build option LSU_MISALIGN_TRAP_EN: misaligned H/W accesses raise err; otherwise they are truncated.
module lsu_writeback #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_data,
  input  logic [2:0]  funct3,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic [4:0]  rd_addr_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        err
);

  // Counter only needs to reach TIMEOUT-1; the abort fires on that value.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2,
    S_WB     = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] tmo_cnt;

  // Op fields captured at accept and needed later to shape the load result.
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic          rw_q;
  logic [4:0]    rd_q;

  // Accept-time decode.
  logic          is_mem;
  logic          bad_op;
  logic          trap_mis;
  logic [1:0]    off_in;
  logic [31:0]   st_wdata;
  logic [3:0]    st_wstrb;

  // Load-return shaping.
  logic [31:0]   lane;
  logic [31:0]   ld_data;
  logic          wb_ok;

  assign in_ready = (state == S_IDLE);
  assign wb_ok    = rw_q && (rd_q != 5'd0);

  // Classify the incoming op and work out the byte offset the access really uses.
  always_comb begin
    is_mem = mem_read || mem_write;
    bad_op = is_mem && ((mem_read && mem_write) ||
                        (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111));
`ifdef LSU_MISALIGN_TRAP_EN
    trap_mis = is_mem && (((funct3[1:0] == 2'b01) && alu_result[0]) ||
                          ((funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00)));
`else
    trap_mis = 1'b0;
`endif
    // Misaligned offsets collapse to the natural boundary of the access size.
    case (funct3[1:0])
      2'b00:   off_in = alu_result[1:0];
      2'b01:   off_in = {alu_result[1], 1'b0};
      default: off_in = 2'b00;
    endcase
  end

  // Replicate store data across all lanes so the strobe alone selects the bytes written.
  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{rs2_data[7:0]}};
        st_wstrb = 4'b0001 << off_in;
      end
      2'b01: begin
        st_wdata = {2{rs2_data[15:0]}};
        st_wstrb = 4'b0011 << off_in;
      end
      default: begin
        st_wdata = rs2_data;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Pull the addressed lane down to bit 0 and extend it according to the captured funct3.
  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_data = {24'd0, lane[7:0]};
      3'b101:  ld_data = {16'd0, lane[15:0]};
      default: ld_data = lane;
    endcase
  end

  // Transaction sequencer; every bus and register-file output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tmo_cnt   <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      rw_q      <= 1'b0;
      rd_q      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      wb_en     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      err       <= 1'b0;
    end else begin
      // wb_en and err are single-cycle pulses.
      wb_en <= 1'b0;
      err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            f3_q  <= funct3;
            off_q <= off_in;
            rw_q  <= reg_write;
            rd_q  <= rd_addr_in;
            if (!is_mem) begin
              // Plain ALU result: write back on the next cycle.
              state   <= S_WB;
              wb_en   <= reg_write && (rd_addr_in != 5'd0);
              wb_addr <= rd_addr_in;
              wb_data <= alu_result;
            end else if (bad_op || trap_mis) begin
              // Rejected before touching the bus; stage stays ready.
              err <= 1'b1;
            end else begin
              state     <= S_REQ;
              tmo_cnt   <= '0;
              mem_req   <= 1'b1;
              mem_we    <= mem_write;
              mem_addr  <= {alu_result[31:2], 2'b00};
              mem_wdata <= mem_write ? st_wdata : 32'd0;
              mem_wstrb <= mem_write ? st_wstrb : 4'b0000;
            end
          end
        end

        S_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              state <= S_IDLE;
            end else if (mem_rvalid) begin
              // Zero-wait memory: data arrives with the grant.
              state   <= S_WB;
              wb_en   <= wb_ok;
              wb_addr <= rd_q;
              wb_data <= ld_data;
            end else begin
              state   <= S_WAIT_R;
              tmo_cnt <= '0;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
            state   <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end

        S_WAIT_R: begin
          if (mem_rvalid) begin
            state   <= S_WB;
            wb_en   <= wb_ok;
            wb_addr <= rd_q;
            wb_data <= ld_data;
          end else if (tmo_cnt == TMO_LAST) begin
            // Give up; any rvalid arriving later lands in IDLE and is ignored.
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end

        S_WB: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_writeback.sv
// Bench for lsu_writeback: table of directed ops, random ops scored by a byte-level model,
// plus hand sequences for late rvalid and reset during a pending load.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_lsu_writeback;
  localparam int TO    = 6;
  localparam int NEVER = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_result = '0;
  logic [31:0] rs2_data = '0;
  logic [2:0]  funct3 = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        reg_write = 1'b0;
  logic [4:0]  rd_addr_in = '0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        err;

  lsu_writeback #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .rs2_data(rs2_data), .funct3(funct3),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .rd_addr_in(rd_addr_in), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  int nvec  = 0;
  int nfail = 0;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [2:0]  f3;
    logic        ld;
    logic        st;
    logic        rw;
    logic [4:0]  rdad;
    logic [31:0] rdata;
    int          gd;      // REQ cycles without grant before the grant (NEVER = never)
    int          rvd;     // WAIT_R cycles before rvalid; 0 = with grant (NEVER = never)
    logic        e_err;
    logic        e_bus;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic        e_wb;
    logic [31:0] e_wbd;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] rs2, input logic [2:0] f3,
                              input logic ld, input logic st, input logic rw, input logic [4:0] rdad,
                              input logic [31:0] rdata, input int gd, input int rvd,
                              input logic e_err, input logic e_bus, input logic [31:0] e_addr,
                              input logic [31:0] e_wdata, input logic [3:0] e_wstrb,
                              input logic e_wb, input logic [31:0] e_wbd);
    vec_t v;
    v.alu = alu; v.rs2 = rs2; v.f3 = f3; v.ld = ld; v.st = st; v.rw = rw; v.rdad = rdad;
    v.rdata = rdata; v.gd = gd; v.rvd = rvd;
    v.e_err = e_err; v.e_bus = e_bus; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_wstrb = e_wstrb; v.e_wb = e_wb; v.e_wbd = e_wbd;
    return v;
  endfunction

  // Reference model: outcome of one op from byte-level arithmetic on the access rules.
  function automatic void model(inout vec_t v);
    int     nbytes;
    int     a;
    int     off;
    longint val;
    longint span;
    v.e_err = 0; v.e_bus = 0; v.e_addr = 0; v.e_wdata = 0; v.e_wstrb = 0; v.e_wb = 0; v.e_wbd = 0;
    if (!v.ld && !v.st) begin
      v.e_wb  = v.rw && (v.rdad != 0);
      v.e_wbd = v.alu;
      return;
    end
    if ((v.ld && v.st) || v.f3 == 3 || v.f3 == 6 || v.f3 == 7) begin
      v.e_err = 1;
      return;
    end
    nbytes = 1 << (v.f3 % 4);
    a      = int'(v.alu % 4);
`ifdef LSU_MISALIGN_TRAP_EN
    if (a % nbytes != 0) begin
      v.e_err = 1;
      return;
    end
`endif
    off      = (a / nbytes) * nbytes;
    v.e_bus  = 1;
    v.e_addr = v.alu - 32'(a);
    if (v.st) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= off && i < off + nbytes) v.e_wstrb[i] = 1'b1;
        v.e_wdata = v.e_wdata | (((v.rs2 >> (8 * (i % nbytes))) & 32'hFF) << (8 * i));
      end
      if (v.gd == NEVER) v.e_err = 1;
      return;
    end
    if (v.gd == NEVER || v.rvd == NEVER) begin
      v.e_err = 1;
      return;
    end
    span = longint'(1) << (8 * nbytes);
    val  = longint'(v.rdata >> (8 * off)) % span;
    if (v.f3 < 4 && nbytes < 4 && val >= span / 2) val = val - span;
    v.e_wbd = 32'(val);
    v.e_wb  = v.rw && (v.rdad != 0);
  endfunction

  // Issue one op, play the bus side, and score everything observed until the stage is idle again.
  task automatic run_op(input vec_t v, input string tag);
    int          reqc = 0, waitc = 0, errc = 0, wbc = 0;
    bit          bus = 0, gnt_given = 0, rv_given = 0, done = 0, unstable = 0;
    logic        c_we = 0;
    logic [31:0] c_addr = 0, c_wdata = 0, wb_a = 0, wb_d = 0;
    logic [3:0]  c_wstrb = 0;
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    check({tag, ".ready_before"}, in_ready, 1'b1);
    alu_result = v.alu; rs2_data = v.rs2; funct3 = v.f3; mem_read = v.ld; mem_write = v.st;
    reg_write = v.rw; rd_addr_in = v.rdad; mem_rdata = v.rdata; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (err) errc++;
      if (wb_en) begin wbc++; wb_a = wb_addr; wb_d = wb_data; end
      if (mem_req) begin
        if (!bus) begin c_we = mem_we; c_addr = mem_addr; c_wdata = mem_wdata; c_wstrb = mem_wstrb; end
        else if ({mem_we, mem_addr, mem_wdata, mem_wstrb} !== {c_we, c_addr, c_wdata, c_wstrb}) unstable = 1;
        bus = 1;
        reqc++;
        if (v.gd != NEVER && reqc == v.gd + 1) begin
          mem_gnt = 1'b1; gnt_given = 1;
          if (v.ld && v.rvd == 0) begin mem_rvalid = 1'b1; rv_given = 1; end
        end
      end else if (gnt_given && v.ld && !rv_given && !in_ready) begin
        waitc++;
        if (waitc == v.rvd) begin mem_rvalid = 1'b1; rv_given = 1; end
      end
      if (in_ready) begin done = 1; break; end
      @(negedge clk);
    end
    check({tag, ".finished"}, done, 1'b1);
    check({tag, ".err"}, errc, v.e_err ? 1 : 0);
    check({tag, ".bus"}, bus, v.e_bus);
    if (v.e_bus) begin
      check({tag, ".we"}, c_we, v.st);
      check({tag, ".addr"}, c_addr, v.e_addr);
      check({tag, ".wstrb"}, c_wstrb, v.e_wstrb);
      if (v.st) check({tag, ".wdata"}, c_wdata, v.e_wdata);
      check({tag, ".req_cycles"}, reqc, (v.gd == NEVER) ? TO : v.gd + 1);
      check({tag, ".req_stable"}, unstable, 1'b0);
      if (v.ld && v.gd != NEVER) check({tag, ".wait_cycles"}, waitc, (v.rvd == NEVER) ? TO : v.rvd);
    end
    check({tag, ".wb_count"}, wbc, v.e_wb ? 1 : 0);
    if (v.e_wb) begin
      check({tag, ".wb_addr"}, wb_a, v.rdad);
      check({tag, ".wb_data"}, wb_d, v.e_wbd);
    end
  endtask

  vec_t tbl[$];
  logic [2:0] f3tab [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd7};

  initial begin
    //            alu           rs2           f3    ld st rw rd  rdata         gd     rvd    err bus addr          wdata         wstrb    wb wbd
    tbl.push_back(mk(32'h1234,      0,            3'd0, 0, 0, 1, 5,  0,            0,     0,     0,  0,  0,            0,            4'b0000, 1, 32'h1234));
    tbl.push_back(mk(32'h103,       32'hAB,       3'd0, 0, 1, 0, 0,  0,            2,     0,     0,  1,  32'h100,      32'hABABABAB, 4'b1000, 0, 0));
    tbl.push_back(mk(32'h102,       0,            3'd0, 1, 0, 1, 7,  32'h00800000, 0,     0,     0,  1,  32'h100,      0,            4'b0000, 1, 32'hFFFFFF80));
    tbl.push_back(mk(32'h102,       0,            3'd4, 1, 0, 1, 7,  32'h00800000, 0,     0,     0,  1,  32'h100,      0,            4'b0000, 1, 32'h00000080));
    tbl.push_back(mk(32'h2,         0,            3'd1, 1, 0, 1, 0,  32'h80010000, 1,     2,     0,  1,  32'h0,        0,            4'b0000, 0, 0));
    tbl.push_back(mk(32'h2,         0,            3'd5, 1, 0, 1, 9,  32'h80010000, 0,     3,     0,  1,  32'h0,        0,            4'b0000, 1, 32'h00008001));
    tbl.push_back(mk(32'h2,         0,            3'd1, 1, 0, 1, 10, 32'h80010000, 2,     1,     0,  1,  32'h0,        0,            4'b0000, 1, 32'hFFFF8001));
    tbl.push_back(mk(32'h102,       32'h1234BEEF, 3'd1, 0, 1, 0, 0,  0,            0,     0,     0,  1,  32'h100,      32'hBEEFBEEF, 4'b1100, 0, 0));
    tbl.push_back(mk(32'h200,       32'hDEADBEEF, 3'd2, 0, 1, 1, 3,  0,            1,     0,     0,  1,  32'h200,      32'hDEADBEEF, 4'b1111, 0, 0));
    tbl.push_back(mk(32'h40,        0,            3'd2, 1, 0, 1, 2,  32'h11223344, 1,     NEVER, 1,  1,  32'h40,       0,            4'b0000, 0, 0));
    tbl.push_back(mk(32'h44,        32'h5,        3'd2, 0, 1, 0, 0,  0,            NEVER, 0,     1,  1,  32'h44,       32'h5,        4'b1111, 0, 0));
    tbl.push_back(mk(32'h48,        0,            3'd2, 1, 1, 1, 4,  0,            0,     0,     1,  0,  0,            0,            4'b0000, 0, 0));
    tbl.push_back(mk(32'h48,        0,            3'd3, 1, 0, 1, 4,  0,            0,     0,     1,  0,  0,            0,            4'b0000, 0, 0));
    tbl.push_back(mk(32'h77,        0,            3'd7, 0, 0, 0, 6,  0,            0,     0,     0,  0,  0,            0,            4'b0000, 0, 0));
`ifdef LSU_MISALIGN_TRAP_EN
    tbl.push_back(mk(32'h6,         0,            3'd2, 1, 0, 1, 3,  32'hCAFEF00D, 0,     0,     1,  0,  0,            0,            4'b0000, 0, 0));
`else
    tbl.push_back(mk(32'h6,         0,            3'd2, 1, 0, 1, 3,  32'hCAFEF00D, 0,     0,     0,  1,  32'h4,        0,            4'b0000, 1, 32'hCAFEF00D));
`endif

    repeat (2) @(negedge clk);
    check("reset.ctrl", {in_ready, mem_req, mem_we, wb_en, err, mem_wstrb, wb_addr}, {1'b1, 13'd0});
    check("reset.data", {mem_addr, mem_wdata} | {32'd0, wb_data}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) run_op(tbl[i], $sformatf("tbl%0d", i));

    // Late rvalid after a WAIT_R timeout must be ignored.
    run_op(tbl[9], "late_rv_setup");
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0BADF00D;
    @(negedge clk);
    check("late_rv.quiet1", {wb_en, err, in_ready}, 3'b001);
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("late_rv.quiet2", {wb_en, err, in_ready}, 3'b001);

    for (int n = 0; n < 150; n++) begin
      vec_t v;
      int   k;
      k      = $urandom_range(0, 9);
      v.alu  = $urandom;
      v.rs2  = $urandom;
      v.f3   = f3tab[$urandom_range(0, 9)];
      v.ld   = (k >= 2 && k <= 5) || k == 9;
      v.st   = (k >= 6);
      v.rw   = 1'($urandom_range(0, 1));
      v.rdad = 5'($urandom_range(0, 31));
      v.rdata = $urandom;
      v.gd   = ($urandom_range(0, 12) == 0) ? NEVER : int'($urandom_range(0, 3));
      v.rvd  = ($urandom_range(0, 12) == 0) ? NEVER : int'($urandom_range(0, 3));
      model(v);
      run_op(v, $sformatf("rnd%0d", n));
    end

    // Reset while a load sits in WAIT_R: everything returns to reset values.
    alu_result = 32'h10; funct3 = 3'd2; mem_read = 1'b1; mem_write = 1'b0;
    reg_write = 1'b1; rd_addr_in = 5'd4; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_mid.req", mem_req, 1'b1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid.waiting", {in_ready, mem_req}, 2'b00);
    rst_n = 1'b0;
    #1;
    check("rst_mid.ctrl", {in_ready, mem_req, mem_we, wb_en, err, mem_wstrb, wb_addr}, {1'b1, 13'd0});
    check("rst_mid.data", {mem_addr, mem_wdata} | {32'd0, wb_data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("rst_mid.no_wb", {wb_en, err}, 2'b00);
    run_op(tbl[0], "after_rst");
    run_op(tbl[2], "after_rst_ld");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
